// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
package fetch_stage_pkg;

    localparam int PC_WIDTH_DEF    = 20;
    localparam int INSTR_WIDTH_DEF = 32;

    localparam logic [2:0] JMP_NONE = 3'd0;
    localparam logic [2:0] JMP_REL  = 3'd1;
    localparam logic [2:0] JMP_ABS  = 3'd2;
    localparam logic [2:0] JMP_LINK = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {word, pc} FIFO; slot 0 is always the head, flush empties it.
module fetch_queue #(
    parameter int PC_WIDTH    = 20,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [INSTR_WIDTH-1:0] word_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [INSTR_WIDTH-1:0] w0_q, w0_d, w1_q, w1_d;
    logic [PC_WIDTH-1:0]    p0_q, p0_d, p1_q, p1_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   do_push, do_pop;

    assign do_pop  = pop_i & (cnt_q != 2'd0);
    assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

    always_comb begin
        w0_d  = w0_q;
        w1_d  = w1_q;
        p0_d  = p0_q;
        p1_d  = p1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        w0_d = word_i;
                        p0_d = pc_i;
                    end else begin
                        w1_d = word_i;
                        p1_d = pc_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    w0_d  = w1_q;
                    p0_d  = p1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        w0_d = word_i;
                        p0_d = pc_i;
                    end else begin
                        w0_d = w1_q;
                        p0_d = p1_q;
                        w1_d = word_i;
                        p1_d = pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w0_q  <= '0;
            w1_q  <= '0;
            p0_q  <= '0;
            p1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            w0_q  <= w0_d;
            w1_q  <= w1_d;
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_o  = w0_q;
    assign pc_o    = p0_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks req/ack to imem, feeds decode via a
// two-entry queue and squashes wrong-path fetches on execute redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic [8:0]             pcchange,
    input  logic [2:0]             pcjumpenable,
    input  logic [5:0]             pclocation,
    output logic [PC_WIDTH-1:0]    previous_programcounter,
    output logic                   link_we,
    output logic [PC_WIDTH-1:0]    link_data
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, stale_q, stale_d;
    logic [PC_WIDTH-1:0] prev_q, link_data_q, target;
    logic                link_we_q, redir, push, pop, accept;
    logic                q_full, q_empty;
    logic [1:0]          occ_q, occ_d;

    always_comb begin
        redir  = 1'b0;
        target = prev_q;
        case (pcjumpenable)
            JMP_REL: begin
                redir  = 1'b1;
                target = prev_q + {{(PC_WIDTH-9){pcchange[8]}}, pcchange};
            end
            JMP_ABS, JMP_LINK: begin
                redir  = 1'b1;
                target = {{(PC_WIDTH-6){1'b0}}, pclocation};
            end
            default: ;
        endcase
    end

    assign instr_valid = ~q_empty;
    assign accept      = instr_valid & instr_ready;
    assign push        = (state_q == ST_FETCH) & imem_ack & ~redir;
    assign pop         = accept & ~redir;
    assign occ_q       = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
    assign occ_d       = occ_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        stale_d = stale_q;
        pc_d    = pc_q;
        if (push) pc_d = pc_q + PC_WIDTH'(1);
        if (redir) pc_d = target;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A request that has not been acked must still drain.
                if (redir && !imem_ack) begin
                    state_d = ST_FLUSH;
                    stale_d = pc_q;
                end else if (!redir && imem_ack && occ_d == 2'd2) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: if (redir || occ_d != 2'd2) state_d = ST_FETCH;
            ST_FLUSH: if (imem_ack) state_d = ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            stale_q     <= '0;
            prev_q      <= RESET_PC;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stale_q   <= stale_d;
            link_we_q <= redir && (pcjumpenable == JMP_LINK);
            if (accept) prev_q <= instr_pc;
            if (redir && pcjumpenable == JMP_LINK) link_data_q <= prev_q + PC_WIDTH'(1);
        end
    end

    fetch_queue #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_queue (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (redir),
        .push_i  (push),
        .pop_i   (pop),
        .word_i  (imem_rdata),
        .pc_i    (pc_q),
        .word_o  (instr),
        .pc_o    (instr_pc),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign imem_req  = (state_q == ST_FETCH) | (state_q == ST_FLUSH);
    assign imem_addr = (state_q == ST_FLUSH) ? stale_q : pc_q;

    assign previous_programcounter = prev_q;
    assign link_we                 = link_we_q;
    assign link_data               = link_data_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed redirects, backpressure, resets.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack;
    logic [19:0] imem_addr;
    logic [31:0] imem_rdata, instr;
    logic [19:0] instr_pc, prev_pc, link_data;
    logic        instr_valid, link_we;
    logic        instr_ready = 1'b0;
    logic [8:0]  pcchange = '0;
    logic [2:0]  pcjumpenable = '0;
    logic [5:0]  pclocation = '0;

    logic        force_ack = 1'b0;
    int          delay = 0;
    int          wcnt = 0;
    int          total = 0;
    int          passed = 0;
    logic [19:0] exp_q[$];

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock                   (clock),
        .reset                   (reset),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .instr                   (instr),
        .instr_pc                (instr_pc),
        .instr_valid             (instr_valid),
        .instr_ready             (instr_ready),
        .pcchange                (pcchange),
        .pcjumpenable            (pcjumpenable),
        .pclocation              (pclocation),
        .previous_programcounter (prev_pc),
        .link_we                 (link_we),
        .link_data               (link_data)
    );

    function automatic logic [31:0] word_of(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    always_comb begin
        imem_rdata = force_ack ? 32'hDEADBEEF : word_of(imem_addr);
        imem_ack   = force_ack | (imem_req & (wcnt >= delay));
    end

    always @(posedge clock) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    always @(negedge clock) begin
        if (reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_accept: got pc %h expected none", instr_pc);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", {12'h0, instr_pc}, {12'h0, e});
                chk("sb_word", instr, word_of(e));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("wait_valid", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic take(input int n, input logic [19:0] first, output int cyc);
        int got = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(first + 20'(i));
        while (got < n && cyc < 200) begin
            if (instr_valid) begin
                instr_ready = 1'b1;
                got++;
            end else begin
                instr_ready = 1'b0;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        instr_ready = 1'b0;
        if (got != n) chk("take_timeout", got, n);
    endtask

    task automatic redirect(input logic [2:0] m, input logic [8:0] c, input logic [5:0] l);
        @(posedge clock);
        #1;
        pcjumpenable = m;
        pcchange     = c;
        pclocation   = l;
        @(posedge clock);
        #1;
        pcjumpenable = '0;
        pcchange     = '0;
        pclocation   = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"}, {12'h0, imem_addr}, 32'h0);
        chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_ipc"}, {12'h0, instr_pc}, 32'h0);
        chk({tag, "_prev"}, {12'h0, prev_pc}, 32'h0);
        chk({tag, "_lwe"}, {31'h0, link_we}, 32'h0);
        chk({tag, "_ldata"}, {12'h0, link_data}, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
    endtask

    initial begin
        int cyc;
        #1 reset = 1'b0;
        wait_cycles(2);
        chk_reset_outputs("rst");

        // stream: zero-wait memory, one instruction per cycle
        @(negedge clock);
        reset = 1'b1;
        #1;
        wait_valid();
        take(4, 20'h0, cyc);
        chk("stream_cycles", cyc, 4);
        chk("stream_prev", {12'h0, prev_pc}, 32'h3);

        // backpressure
        wait_cycles(5);
        chk("bp_req", {31'h0, imem_req}, 32'h0);
        chk("bp_valid", {31'h0, instr_valid}, 32'h1);
        chk("bp_head", {12'h0, instr_pc}, 32'h4);
        chk("bp_addr", {12'h0, imem_addr}, 32'h6);
        take(4, 20'h4, cyc);
        take(9, 20'h8, cyc);
        chk("pre_rel_prev", {12'h0, prev_pc}, 32'h10);

        // relative branch -8 from 0x10
        wait_cycles(3);
        redirect(3'd1, 9'h1F8, 6'h0);
        chk("rel_addr", {12'h0, imem_addr}, 32'h8);
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        chk("rel_valid", {31'h0, instr_valid}, 32'h0);
        chk("rel_lwe", {31'h0, link_we}, 32'h0);
        take(2, 20'h8, cyc);

        // absolute to 3, then relative -8 wraps
        wait_cycles(3);
        redirect(3'd2, 9'h0, 6'h03);
        chk("abs_addr", {12'h0, imem_addr}, 32'h3);
        take(1, 20'h3, cyc);
        wait_cycles(3);
        redirect(3'd1, 9'h1F8, 6'h0);
        chk("wrap_addr", {12'h0, imem_addr}, 32'hFFFFB);
        take(6, 20'hFFFFB, cyc);
        chk("wrap_prev", {12'h0, prev_pc}, 32'h0);

        // climb to 0x100, then absolute jump with link
        wait_cycles(3);
        redirect(3'd1, 9'h0FF, 6'h0);
        chk("fwd_addr", {12'h0, imem_addr}, 32'hFF);
        take(2, 20'hFF, cyc);
        wait_cycles(3);
        redirect(3'd3, 9'h0, 6'h2A);
        chk("link_addr", {12'h0, imem_addr}, 32'h2A);
        chk("link_we_hi", {31'h0, link_we}, 32'h1);
        chk("link_data", {12'h0, link_data}, 32'h101);
        wait_cycles(1);
        chk("link_we_lo", {31'h0, link_we}, 32'h0);
        take(1, 20'h2A, cyc);

        // flush of an outstanding slow request
        wait_cycles(3);
        delay = 3;
        redirect(3'd2, 9'h0, 6'h10);
        chk("fl_addr0", {12'h0, imem_addr}, 32'h10);
        redirect(3'd2, 9'h0, 6'h05);
        chk("fl_req", {31'h0, imem_req}, 32'h1);
        chk("fl_stale_addr", {12'h0, imem_addr}, 32'h10);
        chk("fl_valid", {31'h0, instr_valid}, 32'h0);
        take(1, 20'h5, cyc);

        // asynchronous reset while a request is pending
        delay = 8;
        wait_cycles(1);
        chk("ar_pre_req", {31'h0, imem_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("ar");
        #1;
        reset     = 1'b1;
        force_ack = 1'b1;
        @(posedge clock);
        #1;
        force_ack = 1'b0;
        chk("ar_late_ack", {31'h0, instr_valid}, 32'h0);
        delay = 0;
        take(1, 20'h0, cyc);

        wait_cycles(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
